// File: rtl/lsu_pkg.sv
// Shared types and the request legality check for the load/store memory port.
// LSU_MISALIGN_CHECK_EN selects whether misaligned accesses are reported or forced to alignment.
package lsu_pkg;

`ifdef LSU_MISALIGN_CHECK_EN
    localparam bit MISALIGN_CHECK = 1'b1;
`else
    localparam bit MISALIGN_CHECK = 1'b0;
`endif

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // Misalignment only counts as an error when the check is built in.
    function automatic logic lsu_req_err(input logic [2:0] f3, input logic we,
                                         input logic [1:0] lane);
        logic err;
        err = 1'b0;
        case (f3)
            F3_B:    err = 1'b0;
            F3_H:    err = MISALIGN_CHECK && lane[0];
            F3_W:    err = MISALIGN_CHECK && (lane != 2'b00);
            F3_BU:   err = we;
            F3_HU:   err = we || (MISALIGN_CHECK && lane[0]);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data from a memory word,
// and merges sub-word store data into the captured word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[7:0];
        case (lane)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        half_v = lane[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
            F3_BU:   load_data = {24'h0, byte_v};
            F3_H:    load_data = {{16{half_v[15]}}, half_v};
            F3_HU:   load_data = {16'h0, half_v};
            default: load_data = word;
        endcase
    end

    always_comb begin
        store_word = word;
        case (funct3)
            F3_B: begin
                case (lane)
                    2'd0:    store_word[7:0]   = wdata[7:0];
                    2'd1:    store_word[15:8]  = wdata[7:0];
                    2'd2:    store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            F3_H: begin
                if (lane[1]) store_word[31:16] = wdata[15:0];
                else         store_word[15:0]  = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator: turns RV32 B/H/W accesses into word bus cycles with RMW for sub-word stores.
// Latency load 3, SW 2, SB/SH 4, error 1; no response backpressure. LSU_MISALIGN_CHECK_EN reports misalignment.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_val,
    output logic              mem_rw,
    input  logic [DATA_W-1:0] mem_res
);

    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("lsu_mem_port supports DATA_W = 32 only");
        end
    endgenerate

    state_e              state_q, state_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                we_q, we_d;
    logic [1:0]          lane_q, lane_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                resp_err_q, resp_err_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_val_q, mem_val_d;
    logic                mem_rw_q, mem_rw_d;
    logic [1:0]          lane_eff;
    logic [DATA_W-1:0]   load_data;
    logic [DATA_W-1:0]   store_word;

    lsu_align u_align (
        .word       (mem_res),
        .funct3     (funct3_q),
        .lane       (lane_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Without the check, H/W lanes are snapped to natural alignment.
    always_comb begin
        lane_eff = req_addr[1:0];
        if (!MISALIGN_CHECK) begin
            if (req_funct3[1:0] == 2'b10)      lane_eff = 2'b00;
            else if (req_funct3[1:0] == 2'b01) lane_eff[0] = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        we_d         = we_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_addr_d   = mem_addr_q;
        mem_val_d    = mem_val_q;
        mem_rw_d     = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    funct3_d = req_funct3;
                    we_d     = req_we;
                    lane_d   = lane_eff;
                    wdata_d  = req_wdata;
                    if (lsu_req_err(req_funct3, req_we, req_addr[1:0])) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b1;
                    end else if (req_we && (req_funct3 == F3_W)) begin
                        state_d    = ST_WRITE;
                        mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                        mem_val_d  = req_wdata;
                        mem_rw_d   = 1'b0;
                    end else begin
                        state_d    = ST_READ;
                        mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                    end
                end
            end
            ST_READ: state_d = ST_DATA;
            ST_DATA: begin
                if (we_q) begin
                    state_d   = ST_WRITE;
                    mem_val_d = store_word;
                    mem_rw_d  = 1'b0;
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                    resp_err_d   = 1'b0;
                end
            end
            ST_WRITE: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Async reset forces mem_rw high at once so an uncommitted write is abandoned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            funct3_q     <= 3'b000;
            we_q         <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_val_q    <= '0;
            mem_rw_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            funct3_q     <= funct3_d;
            we_q         <= we_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_val_q    <= mem_val_d;
            mem_rw_q     <= mem_rw_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_val    = mem_val_q;
    assign mem_rw     = mem_rw_q;

endmodule
